// File: rtl/lbuf_pkg.sv
// Shared line buffer ring definitions, used by this producer and by the output sync generator.
package lbuf_pkg;

  localparam int NUM_LINES  = 40;
  localparam int LINE_IDX_W = 6;
  localparam int PIX_IDX_W  = 9;
  localparam int LINE_CNT_W = 11;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_VBLANK    = 3'd1,
    ST_LINE_WAIT = 3'd2,
    ST_ACTIVE    = 3'd3,
    ST_LINE_DONE = 3'd4
  } lbuf_state_t;

endpackage

// File: rtl/sync_edge_det.sv
// Registered falling-edge detector for a negative-polarity sync already in the PCLK domain.
module sync_edge_det (
  input  logic clk,
  input  logic reset_n,
  input  logic sync_in,
  output logic fall
);

  logic prev;

  // Reset to 1 so a sync that is already low at reset release reads as a fresh edge.
  always_ff @(posedge clk) begin
    if (!reset_n) prev <= 1'b1;
    else          prev <= sync_in;
  end

  assign fall = prev & ~sync_in;

endmodule

// File: rtl/lbuf_writer.sv
// Line buffer ring producer: tracks source syncs and writes active pixels at (line, pixel).
// Optional sync measurement counters are built only when LBUF_WR_MEASURE_EN is defined.
//
// state        | meaning
// -------------+--------------------------------------------------------------
// ST_IDLE      | frame complete or after reset, waiting for VSYNC fall
// ST_VBLANK    | counting HSYNC falls up to the first active line
// ST_LINE_WAIT | waiting for the HSYNC fall that opens the next active line
// ST_ACTIVE    | counting pixels and writing the H_START window
// ST_LINE_DONE | line accounting after the last pixel of a line was written
module lbuf_writer
  import lbuf_pkg::*;
#(
  parameter int H_ACTIVE  = 384,
  parameter int V_ACTIVE  = 224,
  parameter int V_START   = 16,
  parameter int NUM_LINES = lbuf_pkg::NUM_LINES
) (
  input  logic        PCLK,
  input  logic        reset_n,
  input  logic        HSYNC_ref,
  input  logic        VSYNC_ref,
  input  logic        pix_en,
  input  logic [15:0] pix_data,
  input  logic [31:0] h_info,
  output logic        wr_en,
  output logic [5:0]  wr_line,
  output logic [8:0]  wr_pixel,
  output logic [15:0] wr_data,
  output logic        frame_start,
  output logic [11:0] meas_htotal,
  output logic [10:0] meas_vtotal
);

  localparam logic [LINE_CNT_W-1:0] V_START_C  = LINE_CNT_W'(V_START);
  localparam logic [LINE_CNT_W-1:0] V_ACTIVE_C = LINE_CNT_W'(V_ACTIVE);
  localparam logic [PIX_IDX_W:0]    H_ACTIVE_C = (PIX_IDX_W+1)'(H_ACTIVE);
  localparam logic [LINE_IDX_W-1:0] LAST_LINE  = LINE_IDX_W'(NUM_LINES - 1);

  lbuf_state_t state, state_nxt;

  logic                  hs_fall, vs_fall;
  logic [PIX_IDX_W-1:0]  h_start, pix_idx;
  logic [PIX_IDX_W:0]    h_end;
  logic [LINE_CNT_W-1:0] line_idx, line_next, act_lines, act_lines_inc;
  logic                  in_window, last_pix, last_line;
  logic                  clr_frame, inc_line, start_lines, clr_pix, inc_pix, do_write, line_end;
  logic                  unused_h_info;

  assign unused_h_info = ^h_info[31:PIX_IDX_W];

  sync_edge_det u_hs_det (.clk(PCLK), .reset_n(reset_n), .sync_in(HSYNC_ref), .fall(hs_fall));
  sync_edge_det u_vs_det (.clk(PCLK), .reset_n(reset_n), .sync_in(VSYNC_ref), .fall(vs_fall));

  assign line_next     = (hs_fall && line_idx != '1) ? line_idx + 1'b1 : line_idx;
  assign act_lines_inc = act_lines + 1'b1;
  assign last_line     = (act_lines_inc == V_ACTIVE_C);
  // Window end is formed at 10 bits so H_START + H_ACTIVE cannot wrap the pixel index.
  assign h_end         = {1'b0, h_start} + H_ACTIVE_C;
  assign in_window     = ({1'b0, pix_idx} >= {1'b0, h_start}) && ({1'b0, pix_idx} < h_end);
  assign last_pix      = ({1'b0, pix_idx} == h_end - 1'b1);

  always_ff @(posedge PCLK) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    clr_frame   = 1'b0;
    inc_line    = 1'b0;
    start_lines = 1'b0;
    clr_pix     = 1'b0;
    inc_pix     = 1'b0;
    do_write    = 1'b0;
    line_end    = 1'b0;
    if (vs_fall) begin
      // Frame restart wins over everything, including a coincident HSYNC fall.
      state_nxt = ST_VBLANK;
      clr_frame = 1'b1;
    end else begin
      unique case (state)
        ST_IDLE: ;
        ST_VBLANK: begin
          inc_line = hs_fall;
          if (line_next >= V_START_C) begin
            state_nxt   = ST_LINE_WAIT;
            start_lines = 1'b1;
          end
        end
        ST_LINE_WAIT: begin
          if (hs_fall) begin
            clr_pix   = 1'b1;
            state_nxt = ST_ACTIVE;
          end
        end
        ST_ACTIVE: begin
          if (hs_fall) begin
            line_end  = 1'b1;
            clr_pix   = 1'b1;
            state_nxt = last_line ? ST_IDLE : ST_ACTIVE;
          end else if (pix_en) begin
            inc_pix = 1'b1;
            if (in_window) begin
              do_write = 1'b1;
              if (last_pix) state_nxt = ST_LINE_DONE;
            end
          end
        end
        ST_LINE_DONE: begin
          line_end = 1'b1;
          if (last_line) begin
            state_nxt = ST_IDLE;
          end else if (hs_fall) begin
            clr_pix   = 1'b1;
            state_nxt = ST_ACTIVE;
          end else begin
            state_nxt = ST_LINE_WAIT;
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge PCLK) begin
    if (!reset_n) begin
      h_start     <= '0;
      pix_idx     <= '0;
      line_idx    <= '0;
      act_lines   <= '0;
      wr_line     <= '0;
      wr_en       <= 1'b0;
      wr_pixel    <= '0;
      wr_data     <= '0;
      frame_start <= 1'b0;
    end else begin
      if (!VSYNC_ref) h_start <= h_info[PIX_IDX_W-1:0];

      if (clr_pix)                      pix_idx <= '0;
      else if (inc_pix && pix_idx != '1) pix_idx <= pix_idx + 1'b1;

      if (clr_frame)     line_idx <= '0;
      else if (inc_line) line_idx <= line_next;

      if (clr_frame)     act_lines <= '0;
      else if (line_end) act_lines <= act_lines_inc;

      if (clr_frame || start_lines) wr_line <= '0;
      else if (line_end)            wr_line <= (wr_line == LAST_LINE) ? '0 : wr_line + 1'b1;

      frame_start <= clr_frame;
      wr_en       <= do_write;
      if (do_write) begin
        wr_pixel <= pix_idx - h_start;
        wr_data  <= pix_data;
      end
    end
  end

`ifdef LBUF_WR_MEASURE_EN
  logic [11:0] htot_cnt;
  logic [10:0] vtot_cnt;

  always_ff @(posedge PCLK) begin
    if (!reset_n) begin
      htot_cnt    <= '0;
      vtot_cnt    <= '0;
      meas_htotal <= '0;
      meas_vtotal <= '0;
    end else begin
      // A pixel coinciding with the HSYNC fall is counted toward the new line.
      if (hs_fall) begin
        meas_htotal <= htot_cnt;
        htot_cnt    <= {11'd0, pix_en};
      end else if (pix_en) begin
        htot_cnt <= htot_cnt + 1'b1;
      end

      if (vs_fall) begin
        meas_vtotal <= vtot_cnt;
        vtot_cnt    <= '0;
      end else if (hs_fall) begin
        vtot_cnt <= vtot_cnt + 1'b1;
      end
    end
  end
`else
  assign meas_htotal = '0;
  assign meas_vtotal = '0;
`endif

endmodule

// File: tb/tb_lbuf_writer.sv
// Self-checking bench for lbuf_writer: expected writes are queued as pixels are driven.
module tb_lbuf_writer;

  logic        PCLK = 1'b0;
  logic        reset_n;
  logic        HSYNC_ref, VSYNC_ref, pix_en;
  logic [15:0] pix_data;
  logic [31:0] h_info;
  logic        wr_en, frame_start;
  logic [5:0]  wr_line;
  logic [8:0]  wr_pixel;
  logic [15:0] wr_data;
  logic [11:0] meas_htotal;
  logic [10:0] meas_vtotal;

  typedef struct packed {
    logic [5:0]  line;
    logic [8:0]  pixel;
    logic [15:0] data;
  } wr_exp_t;

  wr_exp_t exp_q[$];
  wr_exp_t mon_e;
  int n_chk = 0, n_pass = 0, n_wr = 0, wraps = 0, last_wr_line = -1, w0 = 0;

`ifdef LBUF_WR_MEASURE_EN
  localparam logic [31:0] EXP_HTOT = 32'd512;
  localparam logic [31:0] EXP_VTOT = 32'd262;
`else
  localparam logic [31:0] EXP_HTOT = 32'd0;
  localparam logic [31:0] EXP_VTOT = 32'd0;
`endif

  lbuf_writer dut (
    .PCLK(PCLK), .reset_n(reset_n), .HSYNC_ref(HSYNC_ref), .VSYNC_ref(VSYNC_ref),
    .pix_en(pix_en), .pix_data(pix_data), .h_info(h_info),
    .wr_en(wr_en), .wr_line(wr_line), .wr_pixel(wr_pixel), .wr_data(wr_data),
    .frame_start(frame_start), .meas_htotal(meas_htotal), .meas_vtotal(meas_vtotal)
  );

  always #5 PCLK = ~PCLK;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
  endtask

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  task automatic hs_pulse();
    HSYNC_ref = 1'b0;
    repeat (2) tick();
    HSYNC_ref = 1'b1;
    repeat (2) tick();
  endtask

  // Back-to-back pixels; pixel index counts from the last HSYNC fall.
  task automatic send_pixels(input int first, input int n, input int hs, input int line, input bit exp_on);
    for (int i = 0; i < n; i++) begin
      int          idx;
      wr_exp_t     e;
      logic [15:0] d;
      idx = first + i;
      d = 16'($urandom);
      pix_en = 1'b1;
      pix_data = d;
      if (exp_on && idx >= hs && idx < hs + 384) begin
        e.line  = 6'(line);
        e.pixel = 9'(idx - hs);
        e.data  = d;
        exp_q.push_back(e);
      end
      tick();
    end
    pix_en = 1'b0;
  endtask

  task automatic vs_fall(input bit with_hs);
    VSYNC_ref = 1'b0;
    if (with_hs) HSYNC_ref = 1'b0;
    @(posedge PCLK);
    @(negedge PCLK);
    check_val("frame_start_pulse", frame_start, 1);
    @(negedge PCLK);
    check_val("frame_start_single", frame_start, 0);
    @(posedge PCLK);
    #1;
    VSYNC_ref = 1'b1;
    HSYNC_ref = 1'b1;
    repeat (2) tick();
  endtask

  always @(negedge PCLK) begin
    if (reset_n && wr_en) begin
      n_wr++;
      check_val("wr_expected", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        check_val("wr_line", 32'(wr_line), 32'(mon_e.line));
        check_val("wr_pixel", 32'(wr_pixel), 32'(mon_e.pixel));
        check_val("wr_data", 32'(wr_data), 32'(mon_e.data));
      end
      if (last_wr_line == 39 && wr_line == 6'd0) wraps++;
      last_wr_line = int'(wr_line);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; HSYNC_ref = 1'b1; VSYNC_ref = 1'b1;
    pix_en = 1'b0; pix_data = '0; h_info = 32'd10;
    repeat (3) @(posedge PCLK);
    @(negedge PCLK);
    check_val("rst_wr_en", wr_en, 0);
    check_val("rst_wr_line", wr_line, 0);
    check_val("rst_wr_pixel", wr_pixel, 0);
    check_val("rst_wr_data", wr_data, 0);
    check_val("rst_frame_start", frame_start, 0);
    check_val("rst_meas_htotal", meas_htotal, 0);
    check_val("rst_meas_vtotal", meas_vtotal, 0);
    @(posedge PCLK);
    #1 reset_n = 1'b1;
    tick();

    // Frame 1: one full line at H_START=10, then aborted lines through line 223.
    vs_fall(0);
    repeat (16) begin send_pixels(0, 3, 10, 0, 0); hs_pulse(); end
    hs_pulse();
    w0 = n_wr;
    send_pixels(0, 11, 10, 0, 1);
    check_val("first_wr_latency", wr_en, 1);
    check_val("first_wr_pixel", wr_pixel, 0);
    check_val("first_wr_data", wr_data, pix_data);
    send_pixels(11, 389, 10, 0, 1);
    repeat (2) tick();
    check_val("line0_writes", n_wr - w0, 384);
    h_info = 32'd5;
    hs_pulse();
    send_pixels(0, 110, 10, 1, 1);
    hs_pulse();
    for (int l = 2; l < 224; l++) begin
      send_pixels(0, 12, 10, l % 40, 1);
      hs_pulse();
    end
    check_val("frame1_writes", n_wr - w0, 384 + 100 + 222 * 2);
    check_val("frame1_last_line", last_wr_line, 23);
    check_val("frame1_wraps", wraps, 5);
    w0 = n_wr;
    repeat (3) begin hs_pulse(); send_pixels(0, 20, 10, 0, 0); end
    tick();
    check_val("idle_no_writes", n_wr - w0, 0);

    // Frame 2: H_START=5, restart by VSYNC (with coincident HSYNC) during line 50.
    vs_fall(0);
    repeat (16) begin send_pixels(0, 3, 5, 0, 0); hs_pulse(); end
    hs_pulse();
    for (int l = 0; l < 50; l++) begin
      send_pixels(0, 8, 5, l % 40, 1);
      hs_pulse();
    end
    send_pixels(0, 8, 5, 10, 1);
    tick();
    w0 = n_wr;
    vs_fall(1);
    check_val("restart_wr_line", wr_line, 0);
    repeat (16) begin send_pixels(0, 6, 5, 0, 0); hs_pulse(); end
    check_val("restart_vblank_no_writes", n_wr - w0, 0);
    hs_pulse();
    send_pixels(0, 8, 5, 0, 1);
    tick();
    check_val("restart_line0_writes", n_wr - w0, 3);

    // Reset in the same cycle as an in-window pixel.
    w0 = n_wr;
    pix_en = 1'b1;
    pix_data = 16'hBEEF;
    reset_n = 1'b0;
    @(posedge PCLK);
    @(negedge PCLK);
    check_val("reset_no_write", wr_en, 0);
    pix_en = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    repeat (2) begin hs_pulse(); send_pixels(0, 12, 5, 0, 0); end
    tick();
    check_val("post_reset_no_writes", n_wr - w0, 0);

    // Measurement: 262 HSYNC falls per frame, 512 pixels in one blanking line.
    vs_fall(0);
    for (int i = 1; i <= 262; i++) begin
      hs_pulse();
      if (i == 5) send_pixels(0, 512, 5, 0, 0);
      if (i == 6) check_val("meas_htotal", meas_htotal, EXP_HTOT);
    end
    vs_fall(0);
    check_val("meas_vtotal", meas_vtotal, EXP_VTOT);
    check_val("scoreboard_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/lbuf_writer.md
# lbuf_writer

Source-side capture block for the line buffer ring. It detects the reference HSYNC/VSYNC edges of the native game video and counts source pixels and lines. It writes each active pixel into the `NUM_LINES`-deep line buffer at a (line, pixel) address. The output sync generator reads the same ring, so this block is the producer that fills it.

## Interface
Parameters:
- `H_ACTIVE`, 384: active pixels written per line.
- `V_ACTIVE`, 224: active lines written per frame.
- `V_START`, 16: index of the first active line, counted in HSYNC falling edges after the VSYNC falling edge.
- `NUM_LINES`, 40: ring depth in lines. Must match the reader.

Ports:
- `PCLK`  in  1  system clock. One clock domain only.
- `reset_n`  in  1  synchronous, active-low reset.
- `HSYNC_ref`  in  1  source hsync, negative polarity, already synchronised to `PCLK`.
- `VSYNC_ref`  in  1  source vsync, negative polarity, already synchronised to `PCLK`.
- `pix_en`  in  1  source pixel strobe. One `PCLK`-cycle pulse per source pixel.
- `pix_data`  in  16  source pixel, qualified by `pix_en`.
- `h_info`  in  32  runtime config. Bits [8:0] are `H_START`, the pixel index of the first active pixel.
- `wr_en`  out  1  line buffer write strobe.
- `wr_line`  out  6  ring line index, range 0..`NUM_LINES`-1.
- `wr_pixel`  out  9  pixel index within the line.
- `wr_data`  out  16  pixel data to write.
- `frame_start`  out  1  one-cycle pulse on each accepted VSYNC falling edge.
- `meas_htotal`  out  12  measured `pix_en` count per line. Present only when the measurement feature is compiled in (see Configuration).
- `meas_vtotal`  out  11  measured line count per frame. Present only when the measurement feature is compiled in (see Configuration).

## Operation
- Edge detection uses registered `prev_hs` and `prev_vs`, both reset to 1.
  - A falling edge is `prev`=1 and current=0.
- Register `H_START` is loaded from `h_info[8:0]` on every cycle in which `VSYNC_ref`=0. It holds while `VSYNC_ref`=1.
- State machine:
  - IDLE: after reset. On VSYNC fall go to VBLANK, clear `line_idx`, pulse `frame_start`.
  - VBLANK: each HSYNC fall increments `line_idx`. When `line_idx` reaches `V_START`, go to LINE_WAIT and set `wr_line` to 0.
  - LINE_WAIT: on HSYNC fall, clear `pix_idx` and go to ACTIVE.
  - ACTIVE: each `pix_en` increments `pix_idx`. Pixels with `H_START` ≤ `pix_idx` < `H_START`+`H_ACTIVE` are written at `wr_pixel` = `pix_idx`−`H_START`. After the last pixel is written, go to LINE_DONE.
  - LINE_DONE:
    - Increment `act_lines`.
    - Advance `wr_line`, wrapping from `NUM_LINES`-1 to 0.
    - If `act_lines` = `V_ACTIVE`, go to IDLE. Otherwise go to LINE_WAIT.
- Boundary rules:
  - An HSYNC fall during ACTIVE, before all `H_ACTIVE` pixels are written, aborts the line. LINE_DONE accounting is applied in that cycle, and the new line starts directly in ACTIVE with `pix_idx` cleared. Unwritten pixels are left stale.
  - A VSYNC fall in any state other than IDLE restarts the frame: go to VBLANK, clear `line_idx`, `act_lines` and `wr_line`, and pulse `frame_start`.
  - A VSYNC fall and an HSYNC fall in the same cycle: the VSYNC rule takes priority, and that HSYNC edge is not counted.
  - `pix_en` is ignored outside ACTIVE.
  - `pix_idx` saturates at 511.
- Arithmetic: `pix_idx` is 9 bits. `line_idx` is 11 bits and saturates. The comparison `H_START`+`H_ACTIVE` is made at 10-bit width.

## Timing
- Reset values: `wr_en`=0, `wr_line`=0, `wr_pixel`=0, `wr_data`=0, `frame_start`=0, `meas_htotal`=0, `meas_vtotal`=0. State is IDLE.
- Write latency: a `pix_en` sampled in cycle N produces `wr_en`=1 in cycle N+1, with `wr_data`, `wr_pixel` and `wr_line` valid in the same cycle.
- `frame_start` is high in the cycle after the VSYNC-fall cycle.
- Reset asserted mid-frame takes effect on the next `PCLK` edge. No partial write is issued after reset.
- Back-to-back `pix_en` pulses, one every cycle, are supported.

## Configuration
- Macro: `LBUF_WR_MEASURE_EN`.
- Defined:
  - A free-running 12-bit `pix_en` counter is cleared on each HSYNC fall. Its value is latched into `meas_htotal` at that HSYNC fall.
  - An 11-bit HSYNC-fall counter is cleared on each VSYNC fall. Its value is latched into `meas_vtotal` at that VSYNC fall.
  - Both outputs update in the cycle after the edge.
- Undefined: both outputs are constant 0 and the counters are not synthesised.

## Structure
- Shared package `lbuf_pkg`:
  - `NUM_LINES`, `LINE_IDX_W`=6 and `PIX_IDX_W`=9, also used by the sync generator.
  - The state enum.
- One sub-module, `sync_edge_det`: registered falling-edge detector with reset value 1, instantiated for both syncs.

## Test plan
- Reset, then VSYNC fall, 16 HSYNC falls, one HSYNC fall, then 400 `pix_en` pulses with `H_START`=10 → 384 writes on line 0, pixel 0..383. The first write carries the data of the 11th pixel.
- Full 224-line frame → `wr_line` runs 0..39 and wraps to 0 five times, ends at 23. The block returns to IDLE, and further HSYNC falls produce no writes.
- HSYNC fall after 100 active pixels → the line is aborted, `wr_line` advances by 1, and the next line starts at `wr_pixel`=0.
- VSYNC fall at active line 50 → `frame_start` pulses, `wr_line` resets to 0, and no write occurs until line `V_START`.
- `h_info` changed while `VSYNC_ref`=1 → no effect until the next vsync low period.
- With `LBUF_WR_MEASURE_EN` defined and 512 `pix_en` per line, 262 lines → `meas_htotal`=512 and `meas_vtotal`=262 after the second frame.
